// File: rtl/mlp_layer_sequencer.sv
// Input-vector sequencer for a dense layer: captures one vector, streams its
// elements aligned with the layer's synchronous weight reads, then strobes ReLU and done.
module mlp_layer_sequencer #(
    parameter  int N_INPUTS = 4,
    parameter  int IN_WIDTH = 16,
    localparam int IDX_W    = $clog2(N_INPUTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_INPUTS*IN_WIDTH-1:0] inputs_flat,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [IN_WIDTH-1:0]   input_value,
    output logic [IDX_W-1:0]             input_index,
    output logic                         start,
    output logic                         valid,
    output logic                         relu_en,
    output logic                         busy,
    output logic                         done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_RELU  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_INPUTS - 1);

    logic [2:0]          state;
    logic [2:0]          state_next;
    logic [IDX_W-1:0]    k;
    logic [IDX_W-1:0]    k_next;
    logic                accept;
    logic [IN_WIDTH-1:0] vec [N_INPUTS];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        k_next     = k;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                    k_next     = '0;
                end
            end
            S_ISSUE: begin
                // The counter parks on the last element, so no address beyond the vector is ever issued.
                if (k == K_LAST) begin
                    state_next = S_DRAIN;
                end else begin
                    k_next = k + IDX_W'(1);
                end
            end
            S_DRAIN: state_next = S_RELU;
            S_RELU:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            k           <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            input_index <= '0;
            input_value <= '0;
            start       <= 1'b0;
            valid       <= 1'b0;
            relu_en     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            k           <= k_next;
            in_ready    <= (state_next == S_IDLE);
            busy        <= (state_next != S_IDLE);
            input_index <= (state_next == S_ISSUE) ? k_next : '0;
            // Data trails the address by one cycle to meet the weight coming out of the layer's RAM.
            input_value <= (state == S_ISSUE) ? vec[k] : '0;
            start       <= (state == S_ISSUE) && (k == '0);
            valid       <= (state == S_ISSUE) && (k != '0);
            relu_en     <= (state_next == S_RELU);
            done        <= (state_next == S_DONE);
        end
    end

    // NOTE: the vector register is small and must read as zero after reset, so it is cleared like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                vec[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                vec[i] <= inputs_flat[i*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench: two sequencers (4 and 5 inputs) feeding a behavioural dense layer,
// checked cycle by cycle against a timeline model derived from the accept edge.
module tb_mlp_layer_sequencer;

    localparam int W    = 16;
    localparam int MAXN = 5;
    localparam int NEUR = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic                   in_valid_a [2];
    logic [MAXN*W-1:0]      flat_a     [2];
    logic signed [W-1:0]    weight     [2][NEUR][MAXN];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int relu_clip(input longint a);
        if (a < 0) return 0;
        if (a > 32767) return 32767;
        return int'(a);
    endfunction

    function automatic logic [MAXN*W-1:0] pack(input int e0, input int e1, input int e2,
                                               input int e3, input int e4);
        logic [MAXN*W-1:0] v;
        int e [MAXN];
        e = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < MAXN; i++) v[i*W +: W] = e[i][W-1:0];
        return v;
    endfunction

    function automatic logic [MAXN*W-1:0] rand_vec(input int span);
        logic [MAXN*W-1:0] v;
        int e;
        for (int i = 0; i < MAXN; i++) begin
            if (span == 0) e = int'($urandom);
            else           e = int'($urandom_range(0, 2*span)) - span;
            v[i*W +: W] = e[W-1:0];
        end
        return v;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int N  = (g == 0) ? 4 : 5;
        localparam int IW = $clog2(N);

        logic                in_ready, busy, start, valid, relu_en, done;
        logic [IW-1:0]       input_index;
        logic signed [W-1:0] input_value;

        mlp_layer_sequencer #(.N_INPUTS(N), .IN_WIDTH(W)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .inputs_flat (flat_a[g][N*W-1:0]),
            .in_valid    (in_valid_a[g]),
            .in_ready    (in_ready),
            .input_value (input_value),
            .input_index (input_index),
            .start       (start),
            .valid       (valid),
            .relu_en     (relu_en),
            .busy        (busy),
            .done        (done)
        );

        string pfx;
        initial pfx = $sformatf("n%0d_", N);

        // Reference model: one vector in flight, timeline measured from its accept edge.
        int  lcyc    = 0;
        int  acc_cyc = 0;
        bit  active  = 0;
        int  n_acc   = 0;
        int  dut_acc = 0;
        int  exp_val_q [$];
        int  exp_dot_q [$];

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                active = 0;
                exp_val_q.delete();
                exp_dot_q.delete();
            end else begin
                int     c;
                int     el;
                longint dot;
                if (in_valid_a[g] && in_ready) dut_acc++;
                c = lcyc - acc_cyc;
                if (!active || c >= N + 4) begin
                    active = 0;
                    if (in_valid_a[g]) begin
                        active  = 1;
                        acc_cyc = lcyc;
                        n_acc++;
                        for (int i = 0; i < N; i++) begin
                            el = int'($signed(flat_a[g][i*W +: W]));
                            exp_val_q.push_back(el);
                        end
                        for (int j = 0; j < NEUR; j++) begin
                            dot = 0;
                            for (int i = 0; i < N; i++)
                                dot += longint'($signed(flat_a[g][i*W +: W])) * longint'(weight[g][j][i]);
                            exp_dot_q.push_back(relu_clip(dot));
                        end
                    end
                end
                lcyc++;
            end
        end

        // Behavioural dense layer consuming the sequencer's strobes.
        logic signed [W-1:0] w_rd      [NEUR];
        longint              acc       [NEUR];
        int                  layer_out [NEUR];

        always @(posedge clk) begin
            for (int j = 0; j < NEUR; j++) begin
                if (start)      acc[j] = longint'(input_value) * longint'(w_rd[j]);
                else if (valid) acc[j] += longint'(input_value) * longint'(w_rd[j]);
                if (relu_en)    layer_out[j] = relu_clip(acc[j]);
                w_rd[j] = weight[g][j][input_index];
            end
        end

        // Monitor: timeline expectations every cycle; values and layer results popped on strobes.
        always @(negedge clk) begin
            int c;
            bit bsy;
            c   = lcyc - acc_cyc;
            bsy = active && (c <= N + 3);
            check({pfx, "in_ready"}, in_ready, !bsy);
            check({pfx, "busy"},     busy,     bsy);
            check({pfx, "index"},    input_index, (bsy && c >= 1 && c <= N) ? c - 1 : 0);
            check({pfx, "start"},    start,    bsy && c == 2);
            check({pfx, "valid"},    valid,    bsy && c >= 3 && c <= N + 1);
            check({pfx, "relu_en"},  relu_en,  bsy && c == N + 2);
            check({pfx, "done"},     done,     bsy && c == N + 3);
            if (start || valid) begin
                check({pfx, "value_avail"}, exp_val_q.size() > 0, 1);
                if (exp_val_q.size() > 0) check({pfx, "value"}, input_value, exp_val_q.pop_front());
            end else begin
                check({pfx, "value_idle"}, input_value, 0);
            end
            if (done) begin
                check({pfx, "dot_avail"}, exp_dot_q.size() >= NEUR, 1);
                for (int j = 0; j < NEUR; j++)
                    if (exp_dot_q.size() > 0) check({pfx, "layer_out"}, layer_out[j], exp_dot_q.pop_front());
            end
        end
    end

    task automatic send(input int g, input logic [MAXN*W-1:0] v);
        @(negedge clk);
        flat_a[g]     = v;
        in_valid_a[g] = 1'b1;
        @(negedge clk);
        in_valid_a[g] = 1'b0;
        flat_a[g]     = rand_vec(0);
    endtask

    task automatic load_weights();
        for (int g = 0; g < 2; g++)
            for (int j = 0; j < NEUR; j++)
                for (int i = 0; i < MAXN; i++)
                    weight[g][j][i] = W'(int'($urandom_range(0, 40)) - 20);
    endtask

    initial begin
        int a0, a1;
        in_valid_a = '{1'b0, 1'b0};
        flat_a     = '{'0, '0};
        load_weights();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic vectors, then extreme values.
        send(0, pack(1, -3, 2, 4, 0));
        repeat (10) @(negedge clk);
        send(1, pack(1, 2, 3, 4, 5));
        repeat (10) @(negedge clk);
        send(0, pack(-32768, 32767, -32768, 32767, 0));
        repeat (10) @(negedge clk);
        send(1, pack(32767, -32768, -1, 0, 1));
        repeat (10) @(negedge clk);

        // New weights loaded while both lanes are idle.
        load_weights();

        // Continuous in_valid with changing data: one accept per N+4 cycles.
        a0 = g_lane[0].n_acc;
        a1 = g_lane[1].n_acc;
        for (int t = 0; t < 40; t++) begin
            in_valid_a = '{1'b1, 1'b1};
            flat_a[0]  = rand_vec(0);
            flat_a[1]  = rand_vec(0);
            @(negedge clk);
        end
        in_valid_a = '{1'b0, 1'b0};
        check("n4_hold_accepts", g_lane[0].n_acc - a0, (40 + 7) / 8);
        check("n5_hold_accepts", g_lane[1].n_acc - a1, (40 + 8) / 9);
        repeat (12) @(negedge clk);

        // Reset in cycle 3 of an ISSUE phase.
        send(0, pack(100, 200, 300, 400, 0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy",     g_lane[0].busy,        0);
        check("rst_in_ready", g_lane[0].in_ready,    1);
        check("rst_start",    g_lane[0].start,       0);
        check("rst_valid",    g_lane[0].valid,       0);
        check("rst_index",    g_lane[0].input_index, 0);
        check("rst_value",    g_lane[0].input_value, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(0, pack(-7, 9, -11, 13, 0));
        send(1, pack(5, -6, 7, -8, 9));
        repeat (12) @(negedge clk);

        // Randomised traffic with random gaps.
        for (int t = 0; t < 300; t++) begin
            for (int g = 0; g < 2; g++) begin
                in_valid_a[g] = ($urandom_range(0, 3) == 0);
                flat_a[g]     = rand_vec(200);
            end
            @(negedge clk);
        end
        in_valid_a = '{1'b0, 1'b0};
        repeat (12) @(negedge clk);

        check("n4_accept_count", g_lane[0].dut_acc, g_lane[0].n_acc);
        check("n5_accept_count", g_lane[1].dut_acc, g_lane[1].n_acc);
        check("n4_values_drained", g_lane[0].exp_val_q.size(), 0);
        check("n5_values_drained", g_lane[1].exp_val_q.size(), 0);
        check("n4_dots_drained",   g_lane[0].exp_dot_q.size(), 0);
        check("n5_dots_drained",   g_lane[1].exp_dot_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
